queen_run_sequencer: RTL
========================

Name: queen_run_sequencer

Overview:
Host-facing run controller for the eight_queen solver core. It accepts a solve request, checks the solver is idle and pulses its start, then waits for completion under a watchdog. It captures the streamed board rows into a board register and returns the result to the host on a valid/ack handshake. It sits between the system bus glue and eight_queen; the solver's internal controller and datapath are untouched.

Parameters:
N, 8, board size; rows captured and row width.
TIMEOUT_W, 16, watchdog counter width; timeout after 2^TIMEOUT_W-1 cycles in WAIT.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high; clears all state.
req  in  1  host solve request; accepted in IDLE only.
busy  out  1  high in every state except IDLE.
sol_valid  out  1  result available; held until sol_ack.
sol_ack  in  1  host consumes result; honoured only while sol_valid.
sol_board  out  N*N  row r in bits [r*N +: N], one-hot column.
sol_timeout  out  1  result is a watchdog abort; sol_board all zero.
sol_err  out  1  a captured row was not one-hot (ROW_CHECK_EN only; else tied 0).
solver_reset  out  1  reset to eight_queen.
solver_start  out  1  single-cycle start pulse to eight_queen.
solver_ready  in  1  solver idle and able to accept start.
solver_done  in  1  single-cycle pulse; row 0 on solver_out this cycle.
solver_out  in  N  row stream; rows 1..N-1 on the N-1 following cycles.

Behaviour:
- Reset values: busy=0, sol_valid=0, sol_board=0, sol_timeout=0, sol_err=0, solver_start=0. solver_reset=1 while reset is high and for 1 cycle after it deasserts.
- States are IDLE, LAUNCH, WAIT, CAPTURE, PRESENT and FLUSH.
- IDLE: when req=1, go to LAUNCH. sol_board is cleared on entry to LAUNCH.
- LAUNCH: stay here until solver_ready=1. On that cycle, drive solver_start=1 for exactly 1 cycle and move to WAIT. The start pulse is registered, so it appears in the cycle after solver_ready is sampled high.
- WAIT: the watchdog counts from 0 each cycle.
  - When solver_done=1: write solver_out into row 0, set row index=1, go to CAPTURE.
  - When the count reaches all-ones without solver_done: set sol_timeout=1 and go to FLUSH.
  - If solver_done and the terminal count coincide, done wins.
- CAPTURE: each cycle write solver_out into row index, then increment. After row N-1 is written, go to PRESENT. Latency from the solver_done cycle to sol_valid=1 is exactly N cycles.
- PRESENT: sol_valid=1 and sol_board stays stable.
  - On sol_ack=1, clear sol_valid, sol_timeout and sol_err next cycle and return to IDLE.
  - req is ignored here; a new req is accepted no earlier than the cycle after return to IDLE.
- FLUSH: assert solver_reset for 2 cycles, then go to PRESENT with sol_board=0 and sol_timeout=1.
- solver_done outside WAIT is ignored. A spurious done during CAPTURE does not restart row indexing.
- reset mid-operation: return to IDLE the next cycle with all outputs at reset values. A partially captured board is discarded and the solver is reset per the rule above.
- Row index width is clog2(N). The watchdog saturates and never wraps.

Optional Feature:
ROW_CHECK_EN
- Defined: each captured row is checked combinationally for exactly one set bit (no zero rows, no multi-hot). Any violation sets sticky sol_err, which is valid with sol_valid and cleared on ack. A timeout result never sets sol_err.
- Undefined: no checker logic is built and sol_err is constant 0. Port list is identical in both builds.

Decomposition:
- Shared package queen_pkg holds:
  - the state enum;
  - default N=8 and TIMEOUT_W=16;
  - a localparam for the FLUSH length (2);
  - the row-index width function.
- One sub-module, queen_watchdog: a saturating counter with clear and enable inputs and a terminal-count output. Everything else stays in queen_run_sequencer.

Test Plan:
1. Nominal run: req=1 in IDLE, solver_ready=1, solver_done after 100 cycles with rows 0x01,0x10,0x80,0x20,0x04,0x40,0x02,0x08. Expect one solver_start pulse, sol_valid exactly 8 cycles after done, sol_board rows matching, sol_err=0.
2. Ack and back-to-back: hold sol_ack=0 for 20 cycles with req=1 throughout. Expect sol_board stable and no second start. Ack, then expect a second launch no earlier than 1 cycle after return to IDLE.
3. Timeout with TIMEOUT_W=4 and solver_done never asserted. Expect sol_timeout=1 after 15 WAIT cycles, 2 cycles of solver_reset, sol_valid=1 with sol_board=0.
4. Ready gating: solver_ready=0 for 5 cycles after req. Expect solver_start=0 during that time and a single pulse once ready rises.
5. Mid-capture reset: assert reset at row 4. Expect IDLE the next cycle, sol_valid=0, solver_reset high. A fresh run afterwards yields a correct board.
6. With ROW_CHECK_EN, row 3 = 0x18. Expect sol_err=1 with sol_valid, cleared after ack. Without ROW_CHECK_EN, the same stimulus gives sol_err=0.

Source files
------------

// File: rtl/queen_pkg.sv
// Shared types and constants for the eight_queen run sequencer.
package queen_pkg;

   localparam int N_DEF         = 8;
   localparam int TIMEOUT_W_DEF = 16;
   localparam int FLUSH_LEN     = 2;   // cycles of solver_reset after a watchdog abort

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LAUNCH  = 3'd1,
      ST_WAIT    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_PRESENT = 3'd4,
      ST_FLUSH   = 3'd5
   } state_t;

   // Width of an index able to address n items (at least 1 bit).
   function automatic int row_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/queen_watchdog.sv
// Saturating cycle counter; tc is high while the count sits at all-ones.
module queen_watchdog #(
   parameter int W = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   logic [W-1:0] cnt;

   // Count up while enabled, hold at all-ones, restart from zero on clear.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (enable && !tc) begin
         cnt <= cnt + W'(1);
      end
   end

   assign tc = &cnt;

endmodule

// File: rtl/queen_run_sequencer.sv
// Host-facing run controller for the eight_queen solver core.
// Optional build macro ROW_CHECK_EN: one-hot check on every captured row,
// reported through the sticky sol_err flag. Without it sol_err is tied 0.
//
// Host handshake: sol_valid rises when a result is ready and stays high with
// sol_board/sol_timeout/sol_err stable until the host samples sol_ack=1 while
// sol_valid=1; the result is consumed on that clock edge and sol_valid drops
// in the next cycle. sol_ack with sol_valid low is ignored.
module queen_run_sequencer
   import queen_pkg::*;
#(
   parameter int N         = N_DEF,
   parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req,
   output logic           busy,
   output logic           sol_valid,
   input  logic           sol_ack,
   output logic [N*N-1:0] sol_board,
   output logic           sol_timeout,
   output logic           sol_err,
   output logic           solver_reset,
   output logic           solver_start,
   input  logic           solver_ready,
   input  logic           solver_done,
   input  logic [N-1:0]   solver_out
);

   localparam int IW = row_idx_w(N);
   localparam int FW = row_idx_w(FLUSH_LEN);

   state_t         state;
   state_t         state_nx;
   logic [IW-1:0]  row_idx;
   logic [FW-1:0]  flush_cnt;
   logic [N*N-1:0] board_q;
   logic           rst_hold;
   logic           start_q;
   logic           timeout_q;
   logic           wd_tc;

   logic           go_launch;
   logic           go_start;
   logic           cap_first;
   logic           cap_row;
   logic           go_flush;
   logic           ack_take;

   queen_watchdog #(.W(TIMEOUT_W)) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (state != ST_WAIT),
      .enable (state == ST_WAIT),
      .tc     (wd_tc)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode and the datapath strobes that go with each transition.
   always_comb begin
      state_nx  = state;
      go_launch = 1'b0;
      go_start  = 1'b0;
      cap_first = 1'b0;
      cap_row   = 1'b0;
      go_flush  = 1'b0;
      ack_take  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req) begin
               go_launch = 1'b1;
               state_nx  = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            if (solver_ready) begin
               go_start = 1'b1;
               state_nx = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // done takes priority over a coincident terminal count
            if (solver_done) begin
               cap_first = 1'b1;
               state_nx  = ST_CAPTURE;
            end else if (wd_tc) begin
               go_flush = 1'b1;
               state_nx = ST_FLUSH;
            end
         end
         ST_CAPTURE: begin
            cap_row = 1'b1;
            if (row_idx == IW'(N - 1)) begin
               state_nx = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (sol_ack) begin
               ack_take = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            if (flush_cnt == FW'(FLUSH_LEN - 1)) begin
               state_nx = ST_PRESENT;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Board capture, start pulse, timeout flag and solver reset stretching.
   always_ff @(posedge clk) begin
      if (reset) begin
         board_q   <= '0;
         row_idx   <= '0;
         flush_cnt <= '0;
         start_q   <= 1'b0;
         timeout_q <= 1'b0;
         rst_hold  <= 1'b1;
      end else begin
         rst_hold <= 1'b0;
         start_q  <= go_start;
         if (go_launch) begin
            board_q   <= '0;
            timeout_q <= 1'b0;
         end
         if (cap_first) begin
            board_q[N-1:0] <= solver_out;
            row_idx        <= IW'(1);
         end
         if (cap_row) begin
            board_q[row_idx*N +: N] <= solver_out;
            row_idx                 <= row_idx + IW'(1);
         end
         if (go_flush) begin
            board_q   <= '0;
            timeout_q <= 1'b1;
         end
         if (ack_take) begin
            timeout_q <= 1'b0;
         end
         if (state == ST_FLUSH) begin
            flush_cnt <= flush_cnt + FW'(1);
         end else begin
            flush_cnt <= '0;
         end
      end
   end

`ifdef ROW_CHECK_EN
   logic err_q;
   logic row_bad;

   // A legal row has exactly one queen: nonzero with no second set bit.
   always_comb begin
      row_bad = (solver_out == '0) || ((solver_out & (solver_out - N'(1))) != '0);
   end

   // Sticky row error, only raised by rows that are actually captured.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (go_launch || ack_take) begin
         err_q <= 1'b0;
      end else if ((cap_first || cap_row) && row_bad) begin
         err_q <= 1'b1;
      end
   end

   assign sol_err = err_q;
`else
   assign sol_err = 1'b0;
`endif

   assign busy         = (state != ST_IDLE);
   assign sol_valid    = (state == ST_PRESENT);
   assign sol_board    = board_q;
   assign sol_timeout  = timeout_q;
   assign solver_start = start_q;
   assign solver_reset = rst_hold || (state == ST_FLUSH);

endmodule
